// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: prioritises exceptions, interrupts and mret, owns the trap CSRs and privilege level.
// Optional feature macro TRAP_VECTORED_EN enables mtvec vectored mode (interrupts go to BASE + 4*code).
module trap_ctrl #(
   parameter logic [31:0] RESET_MTVEC    = 32'h0000_0000,
   parameter int          RESET_PC_ALIGN = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inst_valid,
   input  logic [31:0] inst_pc,
   input  logic        exc_valid,
   input  logic [3:0]  exc_code,
   input  logic [31:0] exc_tval,
   input  logic        mret,
   input  logic        irq_mei,
   input  logic        irq_mti,
   input  logic        irq_msi,
   input  logic [11:0] csr_addr,
   input  logic        csr_we,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   output logic        csr_hit,
   output logic [2:0]  priv,
   output logic        redirect_req,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ack
);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PENDING = 1'b1} state_t;

   localparam logic [2:0]  PRIV_U          = 3'b000;
   localparam logic [2:0]  PRIV_M          = 3'b011;
   localparam logic [11:0] CSR_MSTATUS     = 12'h300;
   localparam logic [11:0] CSR_MIE         = 12'h304;
   localparam logic [11:0] CSR_MTVEC       = 12'h305;
   localparam logic [11:0] CSR_MEPC        = 12'h341;
   localparam logic [11:0] CSR_MCAUSE      = 12'h342;
   localparam logic [11:0] CSR_MTVAL       = 12'h343;
   localparam logic [11:0] CSR_MIP         = 12'h344;
   localparam logic [3:0]  CODE_ECALL_U    = 4'd8;
   localparam logic [3:0]  CODE_ECALL_M    = 4'd11;
   localparam logic [31:0] PC_MASK         = ~((32'h1 << RESET_PC_ALIGN) - 32'h1);
   localparam logic [31:0] MTVEC_BASE_MASK = PC_MASK & 32'hFFFF_FFFC;
   localparam logic [31:0] MIE_MASK        = 32'h0000_0888;

   state_t      state_r, state_nxt_s;
   logic [2:0]  priv_r, priv_nxt_s;
   logic        st_mie_r, st_mie_nxt_s;
   logic        st_mpie_r, st_mpie_nxt_s;
   logic [1:0]  st_mpp_r, st_mpp_nxt_s;
   logic [31:0] mie_r, mie_nxt_s;
   logic [31:0] mtvec_r, mtvec_nxt_s;
   logic [31:0] mepc_r, mepc_nxt_s;
   logic [31:0] mcause_r, mcause_nxt_s;
   logic [31:0] mtval_r, mtval_nxt_s;
   logic        redirect_req_r, redirect_req_nxt_s;
   logic [31:0] redirect_pc_r, redirect_pc_nxt_s;

   logic        irq_glb_en_s, mei_pend_s, msi_pend_s, mti_pend_s, irq_any_s;
   logic [3:0]  irq_code_s, exc_code_eff_s;
   logic [31:0] mtvec_base_s, irq_target_s, mstatus_s, mip_s;

   function automatic logic [31:0] mtvec_legal(input logic [31:0] wdata);
`ifdef TRAP_VECTORED_EN
      return (wdata & MTVEC_BASE_MASK) | {30'b0, 1'b0, (wdata[1:0] == 2'b01)};
`else
      return wdata & MTVEC_BASE_MASK;
`endif
   endfunction

   assign mstatus_s    = {19'b0, st_mpp_r, 3'b0, st_mpie_r, 3'b0, st_mie_r, 3'b0};
   assign mip_s        = {20'b0, irq_mei, 3'b0, irq_mti, 3'b0, irq_msi, 3'b0};
   assign mtvec_base_s = {mtvec_r[31:2], 2'b00};

   // Interrupt qualification, priority (MEI > MSI > MTI) and target selection
   always_comb begin
      irq_glb_en_s = st_mie_r | (priv_r == PRIV_U);
      mei_pend_s   = irq_mei & mie_r[11] & irq_glb_en_s;
      msi_pend_s   = irq_msi & mie_r[3] & irq_glb_en_s;
      mti_pend_s   = irq_mti & mie_r[7] & irq_glb_en_s;
      irq_any_s    = mei_pend_s | msi_pend_s | mti_pend_s;
      if (mei_pend_s) begin
         irq_code_s = 4'd11;
      end else if (msi_pend_s) begin
         irq_code_s = 4'd3;
      end else if (mti_pend_s) begin
         irq_code_s = 4'd7;
      end else begin
         irq_code_s = 4'd0;
      end
`ifdef TRAP_VECTORED_EN
      if (mtvec_r[1:0] == 2'b01) begin
         irq_target_s = mtvec_base_s + {26'b0, irq_code_s, 2'b00};
      end else begin
         irq_target_s = mtvec_base_s;
      end
`else
      irq_target_s = mtvec_base_s;
`endif
      // An ecall's cause reflects the privilege it was executed from, not the reported code
      if ((exc_code == CODE_ECALL_U) || (exc_code == CODE_ECALL_M)) begin
         exc_code_eff_s = (priv_r == PRIV_M) ? CODE_ECALL_M : CODE_ECALL_U;
      end else begin
         exc_code_eff_s = exc_code;
      end
   end

   // CSR read mux
   always_comb begin
      csr_rdata = 32'h0;
      csr_hit   = 1'b1;
      case (csr_addr)
         CSR_MSTATUS: csr_rdata = mstatus_s;
         CSR_MIE:     csr_rdata = mie_r;
         CSR_MTVEC:   csr_rdata = mtvec_r;
         CSR_MEPC:    csr_rdata = mepc_r;
         CSR_MCAUSE:  csr_rdata = mcause_r;
         CSR_MTVAL:   csr_rdata = mtval_r;
         CSR_MIP:     csr_rdata = mip_s;
         default:     csr_hit   = 1'b0;
      endcase
   end

   // Next-state: CSR writes first, then trap/mret updates override overlapping registers
   always_comb begin
      state_nxt_s        = state_r;
      priv_nxt_s         = priv_r;
      st_mie_nxt_s       = st_mie_r;
      st_mpie_nxt_s      = st_mpie_r;
      st_mpp_nxt_s       = st_mpp_r;
      mie_nxt_s          = mie_r;
      mtvec_nxt_s        = mtvec_r;
      mepc_nxt_s         = mepc_r;
      mcause_nxt_s       = mcause_r;
      mtval_nxt_s        = mtval_r;
      redirect_req_nxt_s = redirect_req_r;
      redirect_pc_nxt_s  = redirect_pc_r;

      if (csr_we) begin
         case (csr_addr)
            CSR_MSTATUS: begin
               st_mie_nxt_s  = csr_wdata[3];
               st_mpie_nxt_s = csr_wdata[7];
               st_mpp_nxt_s  = csr_wdata[12:11];
            end
            CSR_MIE:    mie_nxt_s    = csr_wdata & MIE_MASK;
            CSR_MTVEC:  mtvec_nxt_s  = mtvec_legal(csr_wdata);
            CSR_MEPC:   mepc_nxt_s   = csr_wdata & PC_MASK;
            CSR_MCAUSE: mcause_nxt_s = csr_wdata;
            CSR_MTVAL:  mtval_nxt_s  = csr_wdata;
            default:    begin end
         endcase
      end else begin
      end

      case (state_r)
         ST_IDLE: begin
            if (inst_valid && (exc_valid || irq_any_s || mret)) begin
               redirect_req_nxt_s = 1'b1;
               state_nxt_s        = ST_PENDING;
               if (exc_valid || irq_any_s) begin
                  st_mpie_nxt_s = st_mie_r;
                  st_mie_nxt_s  = 1'b0;
                  st_mpp_nxt_s  = priv_r[1:0];
                  priv_nxt_s    = PRIV_M;
                  mepc_nxt_s    = inst_pc & PC_MASK;
                  if (exc_valid) begin
                     mcause_nxt_s      = {1'b0, 27'b0, exc_code_eff_s};
                     mtval_nxt_s       = exc_tval;
                     redirect_pc_nxt_s = mtvec_base_s;
                  end else begin
                     mcause_nxt_s      = {1'b1, 27'b0, irq_code_s};
                     mtval_nxt_s       = 32'h0;
                     redirect_pc_nxt_s = irq_target_s;
                  end
               end else begin
                  st_mie_nxt_s      = st_mpie_r;
                  st_mpie_nxt_s     = 1'b1;
                  priv_nxt_s        = (st_mpp_r == 2'b11) ? PRIV_M : PRIV_U;
                  st_mpp_nxt_s      = 2'b00;
                  redirect_pc_nxt_s = mepc_r;
               end
            end else begin
            end
         end
         ST_PENDING: begin
            if (redirect_ack) begin
               redirect_req_nxt_s = 1'b0;
               state_nxt_s        = ST_IDLE;
            end else begin
            end
         end
         default: begin
            redirect_req_nxt_s = 1'b0;
            state_nxt_s        = ST_IDLE;
         end
      endcase
   end

   // State and CSR registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= ST_IDLE;
         priv_r         <= PRIV_M;
         st_mie_r       <= 1'b0;
         st_mpie_r      <= 1'b0;
         st_mpp_r       <= 2'b00;
         mie_r          <= 32'h0;
         mtvec_r        <= RESET_MTVEC;
         mepc_r         <= 32'h0;
         mcause_r       <= 32'h0;
         mtval_r        <= 32'h0;
         redirect_req_r <= 1'b0;
         redirect_pc_r  <= 32'h0;
      end else begin
         state_r        <= state_nxt_s;
         priv_r         <= priv_nxt_s;
         st_mie_r       <= st_mie_nxt_s;
         st_mpie_r      <= st_mpie_nxt_s;
         st_mpp_r       <= st_mpp_nxt_s;
         mie_r          <= mie_nxt_s;
         mtvec_r        <= mtvec_nxt_s;
         mepc_r         <= mepc_nxt_s;
         mcause_r       <= mcause_nxt_s;
         mtval_r        <= mtval_nxt_s;
         redirect_req_r <= redirect_req_nxt_s;
         redirect_pc_r  <= redirect_pc_nxt_s;
      end
   end

   assign priv         = priv_r;
   assign redirect_req = redirect_req_r;
   assign redirect_pc  = redirect_pc_r;

endmodule
